// File: rtl/logic_pkg.sv
// Shared types for the registered bitwise logic unit: operation codes and skid-buffer states.
package logic_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise operation and result flags; parity output only with LOGIC_PARITY_EN.
module logic_op_core
    import logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] res_o,
`ifdef LOGIC_PARITY_EN
    output logic             parity_o,
`endif
    output logic             zero_o,
    output logic             ones_o
);

    always_comb begin
        res_o = a_i;
        case (op_i)
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            OP_NAND: res_o = ~(a_i & b_i);
            OP_NOR:  res_o = ~(a_i | b_i);
            OP_XNOR: res_o = ~(a_i ^ b_i);
            OP_NOT:  res_o = ~a_i;
            OP_PASS: res_o = a_i;
            default: res_o = a_i;
        endcase
    end

    assign zero_o = (res_o == '0);
    assign ones_o = &res_o;
`ifdef LOGIC_PARITY_EN
    assign parity_o = ^res_o;
`endif

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit logic unit with a 2-entry skid buffer; LOGIC_PARITY_EN adds out_parity.
// Handshake: a beat transfers on a side in any cycle where its valid and ready are both high.
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_ones,
`ifdef LOGIC_PARITY_EN
    output logic             out_parity,
`endif
    output logic [1:0]       dbg_state_o
);

    state_e           state_q, state_d;
    logic             in_ready_q;
    logic             in_fire, out_fire;
    logic             load_out, load_skid, drain_skid;
    logic [WIDTH-1:0] core_res;
    logic             core_zero, core_ones;
    logic [WIDTH-1:0] out_data_q, skid_data_q;
    logic             out_zero_q, out_ones_q, skid_zero_q, skid_ones_q;
`ifdef LOGIC_PARITY_EN
    logic             core_parity, out_parity_q, skid_parity_q;
`endif

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .op_i     (op_e'(in_op)),
        .a_i      (in_a),
        .b_i      (in_b),
        .res_o    (core_res),
`ifdef LOGIC_PARITY_EN
        .parity_o (core_parity),
`endif
        .zero_o   (core_zero),
        .ones_o   (core_ones)
    );

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        load_out   = 1'b0;
        load_skid  = 1'b0;
        drain_skid = 1'b0;
        case (state_q)
            S_EMPTY: if (in_fire) begin
                state_d  = S_ONE;
                load_out = 1'b1;
            end
            S_ONE: begin
                if (in_fire && !out_fire) begin
                    state_d   = S_FULL;
                    load_skid = 1'b1;
                end else if (!in_fire && out_fire) begin
                    state_d = S_EMPTY;
                end else if (in_fire && out_fire) begin
                    load_out = 1'b1;
                end
            end
            S_FULL: if (out_fire) begin
                state_d    = S_ONE;
                drain_skid = 1'b1;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // in_ready is registered from the next state so upstream never sees a comb path from out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b1;
            out_data_q  <= '0;
            out_zero_q  <= 1'b1;
            out_ones_q  <= 1'b0;
            skid_data_q <= '0;
            skid_zero_q <= 1'b1;
            skid_ones_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_FULL);
            if (load_out) begin
                out_data_q <= core_res;
                out_zero_q <= core_zero;
                out_ones_q <= core_ones;
            end else if (drain_skid) begin
                out_data_q <= skid_data_q;
                out_zero_q <= skid_zero_q;
                out_ones_q <= skid_ones_q;
            end
            if (load_skid) begin
                skid_data_q <= core_res;
                skid_zero_q <= core_zero;
                skid_ones_q <= core_ones;
            end
        end
    end

`ifdef LOGIC_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_parity_q  <= 1'b0;
            skid_parity_q <= 1'b0;
        end else begin
            if (load_out)        out_parity_q <= core_parity;
            else if (drain_skid) out_parity_q <= skid_parity_q;
            if (load_skid)       skid_parity_q <= core_parity;
        end
    end
    assign out_parity = out_parity_q;
`endif

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != S_EMPTY);
    assign out_data    = out_data_q;
    assign out_zero    = out_zero_q;
    assign out_ones    = out_ones_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe (WIDTH=8): directed scenarios plus random traffic vs a queue model.
module tb_logic_unit_pipe;
  import logic_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_zero;
  logic         out_ones;
  logic         out_parity;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  // entry layout: {parity, ones, zero, data}
  logic [W+2:0] exp_q[$];

  always #5 clk = ~clk;

`ifndef LOGIC_PARITY_EN
  assign out_parity = 1'b0;
`endif

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_zero    (out_zero),
    .out_ones    (out_ones),
`ifdef LOGIC_PARITY_EN
    .out_parity  (out_parity),
`endif
    .dbg_state_o (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: per-bit truth tables applied bit by bit, flags from bit counts.
  function automatic logic [W+2:0] model(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    int ones;
    ones = 0;
    for (int i = 0; i < W; i++) begin
      int x, y, v;
      x = int'(a[i]);
      y = int'(b[i]);
      case (op)
        0: v = x * y;
        1: v = (x + y > 0) ? 1 : 0;
        2: v = (x + y) % 2;
        3: v = 1 - x * y;
        4: v = (x + y > 0) ? 0 : 1;
        5: v = 1 - (x + y) % 2;
        6: v = 1 - x;
        default: v = x;
      endcase
      r[i] = (v != 0);
      ones += v;
    end
`ifdef LOGIC_PARITY_EN
    return {ones % 2 == 1, ones == W, ones == 0, r};
`else
    return {1'b0, ones == W, ones == 0, r};
`endif
  endfunction

  // Called just after a falling edge with inputs already set; advances one cycle.
  task automatic tick(output bit acc);
    bit inf, outf;
    logic [W+2:0] e;
    inf  = in_valid && in_ready;
    outf = out_valid && out_ready;
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("in_ready", in_ready, exp_q.size() < 2);
    if (out_valid && exp_q.size() > 0) begin
      e = exp_q[0];
      chk("out_data", out_data, e[W-1:0]);
      chk("out_zero", out_zero, e[W]);
      chk("out_ones", out_ones, e[W+1]);
`ifdef LOGIC_PARITY_EN
      chk("out_parity", out_parity, e[W+2]);
`endif
    end
    if (outf && exp_q.size() > 0) void'(exp_q.pop_front());
    if (inf) exp_q.push_back(model(int'(in_op), in_a, in_b));
    acc = inf;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 64);
    chk("send_accept", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_zero", out_zero, 1);
    chk("rst_out_ones", out_ones, 0);
    chk("rst_out_parity", out_parity, 0);
    chk("rst_state", dbg_state, S_EMPTY);
  endtask

  initial begin
    logic [W-1:0] sweep_tbl [8];
    bit acc;
    int n, txns;
    bit pending;

    sweep_tbl[0] = 8'h30; sweep_tbl[1] = 8'hFC; sweep_tbl[2] = 8'hCC; sweep_tbl[3] = 8'hCF;
    sweep_tbl[4] = 8'h03; sweep_tbl[5] = 8'h33; sweep_tbl[6] = 8'h0F; sweep_tbl[7] = 8'hF0;

    @(negedge clk);
    do_reset();

    // op sweep: result visible one cycle after accept
    out_ready = 1'b1;
    for (int op = 0; op < 8; op++) begin
      send(3'(op), 8'hF0, 8'h3C);
      chk("sweep_valid", out_valid, 1);
      chk("sweep_data", out_data, sweep_tbl[op]);
      idle(1);
    end

    // flags
    send(3'd0, 8'hAA, 8'h55);
    chk("flag_and_data", out_data, 8'h00);
    chk("flag_and_zero", out_zero, 1);
    idle(1);
    send(3'd1, 8'hAA, 8'h55);
    chk("flag_or_data", out_data, 8'hFF);
    chk("flag_or_ones", out_ones, 1);
    idle(1);
    send(3'd0, 8'hF0, 8'h3C);
    chk("flag_parity_30", out_parity, 0);
    idle(1);

    // backpressure: two fill the buffer, third waits until the first drains
    out_ready = 1'b0;
    send(3'd2, 8'h11, 8'h22);
    chk("bp_ready_after_1", in_ready, 1);
    send(3'd2, 8'h33, 8'h44);
    chk("bp_ready_after_2", in_ready, 0);
    chk("bp_state_full", dbg_state, S_FULL);
    in_valid = 1'b1; in_op = 3'd2; in_a = 8'h55; in_b = 8'h66;
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      chk("bp_stall_no_accept", acc, 0);
    end
    out_ready = 1'b1;
    n = 0;
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 64);
    chk("bp_third_wait", n, 2);
    in_valid = 1'b0;
    idle(4);

    // simultaneous in/out every cycle
    send(3'd7, 8'h01, 8'h00);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_op = 3'($urandom_range(0, 7));
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      tick(acc);
      chk("sim_accept", acc, 1);
      chk("sim_state_one", dbg_state, S_ONE);
    end
    in_valid = 1'b0;
    idle(3);

    // reset while full: stored results are discarded
    out_ready = 1'b0;
    send(3'd1, 8'h0F, 8'h10);
    send(3'd2, 8'hFF, 8'h01);
    chk("mid_state_full", dbg_state, S_FULL);
    do_reset();
    out_ready = 1'b1;
    idle(4);

    // random traffic; operands held while a request is pending
    txns = 0;
    pending = 1'b0;
    while (txns < 10000) begin
      if (!pending) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op = 3'($urandom_range(0, 7));
        in_a = 8'($urandom);
        in_b = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
      pending = in_valid && !acc;
      if (acc) txns++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(4);
    chk("final_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
